// File: rtl/csr_timer_unit.sv
// csr_timer_unit: TID/TCFG/TVAL/TICLR registers, countdown FSM and timer
// interrupt pending level. Read data is OR-merged into the CSR read bus by
// the parent.
// Optional feature macro: STABLE_COUNTER_EN (64-bit free-running stable counter).
`timescale 1ns/1ps
module csr_timer_unit #(
   parameter int unsigned TIMER_W = 32,
   parameter logic [31:0] CORE_ID = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        csr_we,
   input  logic [13:0] csr_wnum,
   input  logic [31:0] csr_wvalue,
   input  logic [31:0] csr_wmask,
   input  logic [13:0] csr_rnum,
   output logic [31:0] csr_rvalue,
   output logic        csr_rhit,
   output logic        timer_int,
   output logic [63:0] stable_cnt,
   output logic [31:0] counter_id
);

   localparam logic [13:0] ADDR_TID   = 14'h40;
   localparam logic [13:0] ADDR_TCFG  = 14'h41;
   localparam logic [13:0] ADDR_TVAL  = 14'h42;
   localparam logic [13:0] ADDR_TICLR = 14'h44;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      STOP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        tid_q;
   logic [TIMER_W-1:0] tcfg_q;
   logic [TIMER_W-1:0] tval_q, tval_d;
   logic               pend_q;
   logic               pend_set;

   logic               tid_we, tcfg_we, clr_req;
   logic [31:0]        tid_new, tcfg_wr32;
   logic [TIMER_W-1:0] tcfg_new;
   logic [TIMER_W-1:0] reload_new, reload_cur;

   // Write decode and masked merge of the written value with the old one
   always_comb begin
      tid_we     = csr_we && (csr_wnum == ADDR_TID);
      tcfg_we    = csr_we && (csr_wnum == ADDR_TCFG);
      clr_req    = csr_we && (csr_wnum == ADDR_TICLR) && csr_wmask[0] && csr_wvalue[0];
      tid_new    = (csr_wmask & csr_wvalue) | (~csr_wmask & tid_q);
      tcfg_wr32  = (csr_wmask & csr_wvalue) | (~csr_wmask & 32'(tcfg_q));
      tcfg_new   = TIMER_W'(tcfg_wr32);
      reload_new = {tcfg_new[TIMER_W-1:2], 2'b00};
      reload_cur = {tcfg_q[TIMER_W-1:2], 2'b00};
   end

   // Countdown next-state: expiry/decrement, overridden by any TCFG write
   always_comb begin
      state_d  = state_q;
      tval_d   = tval_q;
      pend_set = 1'b0;
      case (state_q)
         COUNT: begin
            if (tval_q == '0) begin
               pend_set = 1'b1;
               if (tcfg_q[1]) begin
                  tval_d = reload_cur;
               end else begin
                  tval_d  = '1;
                  state_d = STOP;
               end
            end else begin
               tval_d = tval_q - TIMER_W'(1);
            end
         end
         default: ;
      endcase
      if (tcfg_we) begin
         if (tcfg_new[0]) begin
            state_d = COUNT;
            tval_d  = reload_new;
         end else begin
            state_d = IDLE;
            tval_d  = tval_q;
         end
      end
   end

   // FSM state and TVAL registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         tval_q  <= '1;
      end else begin
         state_q <= state_d;
         tval_q  <= tval_d;
      end
   end

   // Software-visible configuration registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tid_q  <= CORE_ID;
         tcfg_q <= '0;
      end else begin
         if (tid_we)  tid_q  <= tid_new;
         if (tcfg_we) tcfg_q <= tcfg_new;
      end
   end

   // Pending level: expiry sets, TICLR clears, set wins on collision
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_set | (pend_q & ~clr_req);
      end
   end

   // Combinational CSR read of current register values
   always_comb begin
      csr_rvalue = '0;
      csr_rhit   = 1'b1;
      case (csr_rnum)
         ADDR_TID:   csr_rvalue = tid_q;
         ADDR_TCFG:  csr_rvalue = 32'(tcfg_q);
         ADDR_TVAL:  csr_rvalue = 32'(tval_q);
         ADDR_TICLR: csr_rvalue = '0;
         default:    csr_rhit   = 1'b0;
      endcase
   end

   assign timer_int  = pend_q;
   assign counter_id = tid_q;

`ifdef STABLE_COUNTER_EN
   logic [63:0] stable_q;

   // Free-running stable counter, wraps naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable_q <= '0;
      end else begin
         stable_q <= stable_q + 64'd1;
      end
   end

   assign stable_cnt = stable_q;
`else
   assign stable_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_csr_timer_unit.sv
// Scoreboard bench for csr_timer_unit: the stimulus queues expected read
// values per cycle, a monitor on the falling edge pops and compares.
`timescale 1ns/1ps
module tb_csr_timer_unit;

   localparam logic [13:0] A_TID   = 14'h40;
   localparam logic [13:0] A_TCFG  = 14'h41;
   localparam logic [13:0] A_TVAL  = 14'h42;
   localparam logic [13:0] A_TICLR = 14'h44;
   localparam logic [31:0] CID     = 32'h0000_0005;
   localparam logic [31:0] ONES    = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        csr_we;
   logic [13:0] csr_wnum;
   logic [31:0] csr_wvalue;
   logic [31:0] csr_wmask;
   logic [13:0] csr_rnum;
   logic [31:0] csr_rvalue;
   logic        csr_rhit;
   logic        timer_int;
   logic [63:0] stable_cnt;
   logic [31:0] counter_id;

   csr_timer_unit #(.TIMER_W(32), .CORE_ID(CID)) dut (
      .clk        (clk),
      .reset      (reset),
      .csr_we     (csr_we),
      .csr_wnum   (csr_wnum),
      .csr_wvalue (csr_wvalue),
      .csr_wmask  (csr_wmask),
      .csr_rnum   (csr_rnum),
      .csr_rvalue (csr_rvalue),
      .csr_rhit   (csr_rhit),
      .timer_int  (timer_int),
      .stable_cnt (stable_cnt),
      .counter_id (counter_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] rv;
      logic        hit;
      logic        ti;
      logic [31:0] id;
      logic [63:0] sc;
   } exp_t;

   exp_t        sb[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_id = CID;
   logic [63:0] ncyc   = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
      end
   endtask

   // Monitor: one expectation per cycle, compared on the falling edge
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.name, ".rvalue"},  64'(csr_rvalue), 64'(e.rv));
         chk({e.name, ".rhit"},    64'(csr_rhit),   64'(e.hit));
         chk({e.name, ".int"},     64'(timer_int),  64'(e.ti));
         chk({e.name, ".id"},      64'(counter_id), 64'(e.id));
         chk({e.name, ".stable"},  stable_cnt,      e.sc);
      end
   end

   task automatic push(input string nm, input logic [13:0] rn, input logic [31:0] rv, input logic ti);
      exp_t e;
      csr_rnum = rn;
      e.name = nm;
      e.rv   = rv;
      e.hit  = (rn == A_TID) || (rn == A_TCFG) || (rn == A_TVAL) || (rn == A_TICLR);
      e.ti   = ti;
      e.id   = exp_id;
`ifdef STABLE_COUNTER_EN
      e.sc   = reset ? 64'd0 : ncyc;
`else
      e.sc   = 64'd0;
`endif
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      csr_we = 1'b0;
      if (reset) ncyc = '0;
      else       ncyc = ncyc + 64'd1;
   endtask

   task automatic wr(input logic [13:0] n, input logic [31:0] v, input logic [31:0] m);
      csr_we     = 1'b1;
      csr_wnum   = n;
      csr_wvalue = v;
      csr_wmask  = m;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; csr_we = 1'b0; csr_wnum = '0; csr_wvalue = '0;
      csr_wmask = '0; csr_rnum = A_TVAL;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // reset values and decode
      push("rst_tval",  A_TVAL,  ONES, 1'b0); step();
      push("rst_tcfg",  A_TCFG,  '0,   1'b0); step();
      push("rst_tid",   A_TID,   CID,  1'b0); step();
      push("rst_ticlr", A_TICLR, '0,   1'b0); step();
      push("unowned",   14'h43,  '0,   1'b0); step();

      // TID masked write, TVAL write ignored
      wr(A_TID, 32'hABCD_1234, 32'hFFFF_0000);
      push("tid_wr", A_TID, CID, 1'b0); step();
      exp_id = 32'hABCD_0005;
      push("tid_rd", A_TID, 32'hABCD_0005, 1'b0); step();
      wr(A_TVAL, 32'h0000_1234, ONES);
      push("tval_wr", A_TVAL, ONES, 1'b0); step();
      push("tval_ro", A_TVAL, ONES, 1'b0); step();

      // one-shot InitVal=4
      wr(A_TCFG, 32'h0000_0011, ONES);
      push("os_wr", A_TVAL, ONES, 1'b0); step();
      for (int i = 16; i >= 0; i--) begin
         push("os_tval", A_TVAL, 32'(i), 1'b0); step();
      end
      repeat (3) begin
         push("os_stop", A_TVAL, ONES, 1'b1); step();
      end

      // periodic InitVal=2
      wr(A_TCFG, 32'h0000_000B, ONES);
      push("per_wr", A_TVAL, ONES, 1'b1); step();
      repeat (2) begin
         for (int i = 8; i >= 0; i--) begin
            push("per_tval", A_TVAL, 32'(i), 1'b1); step();
         end
      end
      wr(A_TICLR, 32'h1, 32'h1);
      push("clr_wr", A_TVAL, 32'd8, 1'b1); step();
      for (int i = 7; i >= 0; i--) begin
         push("clr_tval", A_TVAL, 32'(i), 1'b0); step();
      end
      push("reset_pend", A_TVAL, 32'd8, 1'b1); step();
      for (int i = 7; i >= 1; i--) begin
         push("per_tval2", A_TVAL, 32'(i), 1'b1); step();
      end

      // clear collides with expiry
      wr(A_TICLR, 32'h1, 32'h1);
      push("setclr_wr", A_TVAL, 32'd0, 1'b1); step();
      push("set_wins", A_TVAL, 32'd8, 1'b1); step();
      push("per_tval3", A_TVAL, 32'd7, 1'b1); step();
      push("per_tval3", A_TVAL, 32'd6, 1'b1); step();

      // disable at TVAL=5, then restart with InitVal=1
      wr(A_TCFG, 32'h0, 32'h1);
      push("dis_wr", A_TVAL, 32'd5, 1'b1); step();
      repeat (10) begin
         push("dis_hold", A_TVAL, 32'd5, 1'b1); step();
      end
      push("dis_tcfg", A_TCFG, 32'h0000_000A, 1'b1); step();
      wr(A_TCFG, 32'h0000_0005, ONES);
      push("re_wr", A_TVAL, 32'd5, 1'b1); step();
      for (int i = 4; i >= 0; i--) begin
         push("re_tval", A_TVAL, 32'(i), 1'b1); step();
      end
      push("re_stop", A_TVAL, ONES, 1'b1); step();

      // masked TCFG write does not start counting
      wr(A_TICLR, 32'h1, 32'h1);
      push("clr2_wr", A_TVAL, ONES, 1'b1); step();
      push("clr2", A_TVAL, ONES, 1'b0); step();
      wr(A_TCFG, 32'h0, ONES);
      push("zero_wr", A_TCFG, 32'h5, 1'b0); step();
      wr(A_TCFG, ONES, 32'h0000_0002);
      push("mask_wr", A_TCFG, 32'h0, 1'b0); step();
      push("mask_tcfg", A_TCFG, 32'h2, 1'b0); step();
      repeat (3) begin
         push("mask_idle", A_TVAL, ONES, 1'b0); step();
      end

      // asynchronous reset mid-count
      wr(A_TCFG, 32'h0000_000B, ONES);
      push("ar_wr", A_TVAL, ONES, 1'b0); step();
      for (int i = 8; i >= 0; i--) begin
         push("ar_tval", A_TVAL, 32'(i), 1'b0); step();
      end
      push("ar_tval", A_TVAL, 32'd8, 1'b1); step();
      push("ar_tval", A_TVAL, 32'd7, 1'b1); step();
      push("ar_tval", A_TVAL, 32'd6, 1'b1); step();
      #1;
      reset  = 1'b1;
      exp_id = CID;
      push("arst_tval", A_TVAL, ONES, 1'b0); step();
      push("arst_tcfg", A_TCFG, 32'h0, 1'b0); step();
      reset = 1'b0;
      repeat (3) begin
         push("post_idle", A_TVAL, ONES, 1'b0); step();
      end

      // stable counter
      repeat (4) begin
         push("stable", A_TID, CID, 1'b0); step();
      end
`ifdef STABLE_COUNTER_EN
      force dut.stable_q = 64'hFFFF_FFFF_FFFF_FFFF;
      ncyc = 64'hFFFF_FFFF_FFFF_FFFF;
      push("sc_force", A_TID, CID, 1'b0);
      @(negedge clk);
      #1;
      release dut.stable_q;
      step();
      push("sc_wrap", A_TID, CID, 1'b0); step();
      push("sc_after", A_TID, CID, 1'b0); step();
`endif

      for (int k = 0; k < 5 && sb.size() != 0; k++) @(negedge clk);
      #1;
      chk("sb_drain", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
